// File: rtl/fpu_data_mem.sv
// ============================================================================
// Module   : fpu_data_mem
// Brief    : Word-organised data memory responding on the FPU load/store
//            port. Accepts level-held requests, inserts LATENCY wait states,
//            answers with a one-cycle ready pulse and keeps read data stable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_data_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [29:0] DEPTH_C = 30'(DEPTH_WORDS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        req_both;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]      word_off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             do_access;

    // Decode the latched address; only the word part matters, the byte
    // offset bits are ignored.
    always_comb begin
        word_off  = req_addr[31:2] - ADDR_BASE[31:2];
        in_range  = (req_addr >= ADDR_BASE) && (word_off < DEPTH_C);
        idx       = word_off[IDX_W-1:0];
        do_access = (state == WAIT) && (wait_cnt == 4'd0);
    end

    // Request FSM: accept in IDLE, count wait states, respond, then hold in
    // DRAIN until the initiator lets go so one request is served only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            req_write <= 1'b0;
            req_both  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_re || mem_we) begin
                        req_addr  <= mem_addr;
                        req_wdata <= mem_wdata;
                        req_write <= mem_we;
                        req_both  <= mem_re && mem_we;
                        wait_cnt  <= LAT;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!mem_re && !mem_we) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response outputs: registered on the edge that enters RESP, so ready,
    // error, read data and counters all change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= 32'd0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            rd_count  <= 16'd0;
            wr_count  <= 16'd0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            if (do_access) begin
                mem_ready <= 1'b1;
                mem_err   <= req_both || !in_range;
                if (req_write) begin
                    if (wr_count != 16'hFFFF) begin
                        wr_count <= wr_count + 16'd1;
                    end
                end else begin
                    mem_rdata <= in_range ? mem[idx] : 32'd0;
                    if (rd_count != 16'hFFFF) begin
                        rd_count <= rd_count + 16'd1;
                    end
                end
            end
        end
    end

    // Storage array has no reset; a write commits only at its RESP edge and
    // only when the address decodes inside the array.
    always_ff @(posedge clk) begin
        if (do_access && req_write && in_range && !rst) begin
            mem[idx] <= req_wdata;
        end
    end

endmodule

`default_nettype wire
